eca_job_seq: RTL and testbench

- Job sequencer for the erasure coding accelerator; sits between the register block and the datapath (input buffer, bitmatrix memory, engine, output buffer).
- On a start command it processes N stripes.
- For each stripe, it steps through every parity unit and every GF bit-row: it fetches the bitmatrix row, launches the engine, then commits the parity word to the output buffer.
- After the last parity unit, it releases the stripe from the input buffer and reports completion to the registers.

---
 rtl/eca_pkg.sv | 28 ++
 rtl/eca_job_seq_if.sv | 34 +++
 rtl/eca_row_cnt.sv | 51 +++++
 rtl/eca_job_seq.sv | 167 ++++++++++++++++
 tb/tb_eca_job_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eca_pkg.sv
// Shared definitions for the erasure coding job sequencer.
//   - sequencer FSM state encoding
//   - default geometry (parity units, GF width, stripe counter width)
//   - clog2_min1(): address/index width helper that never returns 0
package eca_pkg;

  localparam int M_PARITY_DEF     = 2;
  localparam int W_GF_DEF         = 8;
  localparam int STRIPE_CNT_W_DEF = 16;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_IN,
    BM_RD,
    BM_WAIT,
    ENG,
    ENG_WAIT,
    OUT_WR,
    REL,
    FIN
  } state_t;

  // A single-entry range still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eca_job_seq_if.sv
// Datapath handshake bundle between the job sequencer and the
// input buffer, bitmatrix memory, engine and output buffer.
//   master : sequencer side (drives requests, release, flush)
//   slave  : datapath side (drives valids, done, full)
interface eca_job_seq_if #(
  parameter int BM_ADDR_W = eca_pkg::clog2_min1(eca_pkg::M_PARITY_DEF * eca_pkg::W_GF_DEF),
  parameter int IDX_W     = eca_pkg::clog2_min1(eca_pkg::M_PARITY_DEF)
);

  logic                 inbuf_stripe_val;
  logic                 inbuf_release;
  logic                 bm_rd_req;
  logic [BM_ADDR_W-1:0] bm_rd_addr;
  logic                 bm_rd_data_val;
  logic                 eng_start;
  logic                 eng_done;
  logic                 eng_flush;
  logic                 outbuf_full;
  logic                 outbuf_wr_req;
  logic [IDX_W-1:0]     outbuf_wr_idx;

  modport master (
    input  inbuf_stripe_val, bm_rd_data_val, eng_done, outbuf_full,
    output inbuf_release, bm_rd_req, bm_rd_addr, eng_start, eng_flush,
           outbuf_wr_req, outbuf_wr_idx
  );

  modport slave (
    output inbuf_stripe_val, bm_rd_data_val, eng_done, outbuf_full,
    input  inbuf_release, bm_rd_req, bm_rd_addr, eng_start, eng_flush,
           outbuf_wr_req, outbuf_wr_idx
  );

endinterface

// File: rtl/eca_row_cnt.sv
// Nested parity-unit (m) / GF bit-row (b) counter for one stripe.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             return to m=0, b=0
//   inc_b           advance to the next bit-row of the current parity unit
//   inc_m           advance to the next parity unit, b back to 0
//   m_idx           current parity unit
//   bm_addr         bitmatrix row address m*W_GF + b
//   last_b, last_m  current row / parity unit is the final one
module eca_row_cnt
  import eca_pkg::*;
#(
  parameter int M_PARITY  = M_PARITY_DEF,
  parameter int W_GF      = W_GF_DEF,
  parameter int BM_ADDR_W = clog2_min1(M_PARITY_DEF * W_GF_DEF),
  parameter int IDX_W     = clog2_min1(M_PARITY_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc_b,
  input  logic                 inc_m,
  output logic [IDX_W-1:0]     m_idx,
  output logic [BM_ADDR_W-1:0] bm_addr,
  output logic                 last_b,
  output logic                 last_m
);

  localparam int B_W = clog2_min1(W_GF);

  logic [B_W-1:0]   b_q;
  logic [IDX_W-1:0] m_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      m_q <= '0;
      b_q <= '0;
    end else if (inc_m) begin
      m_q <= m_q + IDX_W'(1);
      b_q <= '0;
    end else if (inc_b) begin
      b_q <= b_q + B_W'(1);
    end
  end

  assign m_idx   = m_q;
  assign last_b  = (int'(b_q) == W_GF - 1);
  assign last_m  = (int'(m_q) == M_PARITY - 1);
  assign bm_addr = BM_ADDR_W'(int'(m_q) * W_GF + int'(b_q));

endmodule

// File: rtl/eca_job_seq.sv
// Job sequencer: runs N stripes; per stripe walks every parity unit and
// bit-row (bitmatrix fetch -> engine op), commits one parity word per
// unit, then releases the stripe and reports progress.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start/abort     one-cycle command pulses from the register block
//   cfg_stripe_num      stripes in the job, sampled on an accepted start
//   sts_busy            job in progress
//   sts_done/aborted    one-cycle end-of-job pulses
//   sts_stripes_done    stripes completed in the current or last job
//   dp                  datapath handshake bundle (master side)
//
// state    | meaning
// IDLE     | no job; waits for cfg_start
// WAIT_IN  | waits for a full stripe in the input buffer
// BM_RD    | bitmatrix row read request issued
// BM_WAIT  | waits for bitmatrix row data
// ENG      | engine start issued
// ENG_WAIT | waits for engine result
// OUT_WR   | commits parity word once the output buffer has room
// REL      | releases the stripe, bumps the completed count
// FIN      | job done pulse
module eca_job_seq
  import eca_pkg::*;
#(
  parameter int M_PARITY     = M_PARITY_DEF,
  parameter int W_GF         = W_GF_DEF,
  parameter int STRIPE_CNT_W = STRIPE_CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic [STRIPE_CNT_W-1:0] cfg_stripe_num,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    sts_aborted,
  output logic [STRIPE_CNT_W-1:0] sts_stripes_done,
  eca_job_seq_if.master           dp
);

  localparam int BM_ADDR_W = clog2_min1(M_PARITY * W_GF);
  localparam int IDX_W     = clog2_min1(M_PARITY);

  state_t state_q, state_d;

  logic [STRIPE_CNT_W-1:0] num_q;
  logic [IDX_W-1:0]        m_idx, wr_idx_q;
  logic [BM_ADDR_W-1:0]    bm_addr;
  logic                    last_b, last_m;
  logic                    cnt_clr, inc_b, inc_m;
  logic                    accept, start_zero, wr_d, take_abort;
  logic                    release_q, bm_req_q, eng_start_q, flush_q, wr_req_q;

  eca_row_cnt #(
    .M_PARITY  (M_PARITY),
    .W_GF      (W_GF),
    .BM_ADDR_W (BM_ADDR_W),
    .IDX_W     (IDX_W)
  ) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc_b   (inc_b),
    .inc_m   (inc_m),
    .m_idx   (m_idx),
    .bm_addr (bm_addr),
    .last_b  (last_b),
    .last_m  (last_m)
  );

  // sts_busy is low in IDLE and FIN, so an abort there is ignored.
  assign take_abort = cfg_abort && sts_busy;

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    inc_b      = 1'b0;
    inc_m      = 1'b0;
    accept     = 1'b0;
    start_zero = 1'b0;
    wr_d       = 1'b0;
    if (take_abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (cfg_start) begin
          if (cfg_stripe_num == '0) start_zero = 1'b1;
          else begin
            accept  = 1'b1;
            state_d = WAIT_IN;
          end
        end
        WAIT_IN: if (dp.inbuf_stripe_val) begin
          cnt_clr = 1'b1;
          state_d = BM_RD;
        end
        BM_RD:   state_d = BM_WAIT;
        BM_WAIT: if (dp.bm_rd_data_val) state_d = ENG;
        ENG:     state_d = ENG_WAIT;
        ENG_WAIT: if (dp.eng_done) begin
          if (!last_b) begin
            inc_b   = 1'b1;
            state_d = BM_RD;
          end else state_d = OUT_WR;
        end
        OUT_WR: if (!dp.outbuf_full) begin
          wr_d = 1'b1;
          if (!last_m) begin
            inc_m   = 1'b1;
            state_d = BM_RD;
          end else state_d = REL;
        end
        // The count was already bumped on entry to REL.
        REL:     state_d = (sts_stripes_done == num_q) ? FIN : WAIT_IN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulses are registered from the transition taken, so each one is
  // high for exactly the cycle spent in the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      num_q            <= '0;
      sts_stripes_done <= '0;
      sts_busy         <= 1'b0;
      sts_done         <= 1'b0;
      sts_aborted      <= 1'b0;
      release_q        <= 1'b0;
      bm_req_q         <= 1'b0;
      eng_start_q      <= 1'b0;
      flush_q          <= 1'b0;
      wr_req_q         <= 1'b0;
      wr_idx_q         <= '0;
    end else begin
      state_q     <= state_d;
      sts_busy    <= (state_d != IDLE) && (state_d != FIN);
      sts_done    <= start_zero || (state_d == FIN);
      sts_aborted <= take_abort;
      flush_q     <= take_abort;
      release_q   <= (state_d == REL);
      bm_req_q    <= (state_d == BM_RD);
      eng_start_q <= (state_d == ENG);
      wr_req_q    <= wr_d;
      if (wr_d) wr_idx_q <= m_idx;
      if (accept) begin
        num_q            <= cfg_stripe_num;
        sts_stripes_done <= '0;
      end else if (state_d == REL) begin
        sts_stripes_done <= sts_stripes_done + STRIPE_CNT_W'(1);
      end
    end
  end

  assign dp.inbuf_release = release_q;
  assign dp.bm_rd_req     = bm_req_q;
  assign dp.bm_rd_addr    = bm_addr;
  assign dp.eng_start     = eng_start_q;
  assign dp.eng_flush     = flush_q;
  assign dp.outbuf_wr_req = wr_req_q;
  assign dp.outbuf_wr_idx = wr_idx_q;

endmodule

// File: tb/tb_eca_job_seq.sv
module tb_eca_job_seq;

  localparam int M   = 2;
  localparam int W   = 8;
  localparam int SCW = 16;
  localparam int AW  = 4;
  localparam int IW  = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start, cfg_abort;
  logic [SCW-1:0] cfg_stripe_num;
  logic           sts_busy, sts_done, sts_aborted;
  logic [SCW-1:0] sts_stripes_done;

  logic inbuf_val, ob_full, bm_rsp, bm_stray, eng_rsp, eng_stray;
  int   bm_lat = 1, eng_lat = 1, bm_pend = 0, eng_pend = 0;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_bm, n_eng, n_wr, n_rel, n_done, n_ab, n_fl;
  int addr_q[$];
  int idx_q[$];
  logic [6:0] pulses, prev_pulses = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  eca_job_seq_if #(.BM_ADDR_W(AW), .IDX_W(IW)) dp ();

  assign dp.inbuf_stripe_val = inbuf_val;
  assign dp.outbuf_full      = ob_full;
  assign dp.bm_rd_data_val   = bm_rsp | bm_stray;
  assign dp.eng_done         = eng_rsp | eng_stray;

  eca_job_seq #(.M_PARITY(M), .W_GF(W), .STRIPE_CNT_W(SCW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_stripe_num   (cfg_stripe_num),
    .sts_busy         (sts_busy),
    .sts_done         (sts_done),
    .sts_aborted      (sts_aborted),
    .sts_stripes_done (sts_stripes_done),
    .dp               (dp)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_bm = 0; n_eng = 0; n_wr = 0; n_rel = 0; n_done = 0; n_ab = 0; n_fl = 0;
    addr_q.delete();
    idx_q.delete();
  endtask

  task automatic do_start(input int n);
    cfg_stripe_num = SCW'(n);
    cfg_start = 1'b1;
    sync();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    int base = n_done;
    while (n_done == base && k < budget) begin
      sync();
      k++;
    end
    check(tag, n_done - base, 1);
  endtask

  // Reference traffic: every stripe reads rows m*W+b in order and commits m=0..M-1.
  task automatic check_seq(input int ns);
    int exp_a[$];
    int exp_i[$];
    for (int s = 0; s < ns; s++)
      for (int m = 0; m < M; m++) begin
        exp_i.push_back(m);
        for (int b = 0; b < W; b++) exp_a.push_back(m * W + b);
      end
    check("bm_rd_count", addr_q.size(), exp_a.size());
    check("eng_start_count", n_eng, ns * M * W);
    check("wr_count", idx_q.size(), exp_i.size());
    check("release_count", n_rel, ns);
    for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
      check("bm_rd_addr", addr_q[i], exp_a[i]);
    for (int i = 0; i < exp_i.size() && i < idx_q.size(); i++)
      check("wr_idx", idx_q[i], exp_i[i]);
  endtask

  // Bitmatrix memory and engine: respond bm_lat / eng_lat cycles after the request.
  initial begin
    bm_rsp = 1'b0;
    eng_rsp = 1'b0;
    forever begin
      @(negedge clk);
      bm_rsp = 1'b0;
      eng_rsp = 1'b0;
      if (bm_pend > 0) begin
        bm_pend--;
        if (bm_pend == 0) bm_rsp = 1'b1;
      end
      if (eng_pend > 0) begin
        eng_pend--;
        if (eng_pend == 0) eng_rsp = 1'b1;
      end
      if (dp.bm_rd_req) bm_pend = bm_lat;
      if (dp.eng_start) eng_pend = eng_lat;
      if (dp.eng_flush) eng_pend = 0;
    end
  end

  // Monitor: event counts, traffic capture, no pulse held two cycles.
  initial begin
    forever begin
      @(negedge clk);
      pulses = {dp.inbuf_release, dp.bm_rd_req, dp.eng_start, dp.eng_flush,
                dp.outbuf_wr_req, sts_done, sts_aborted};
      if (pulses != '0) check("pulse_repeat", pulses & prev_pulses, 0);
      prev_pulses = pulses;
      if (cfg_start) start_cyc = cyc;
      if (dp.bm_rd_req) begin n_bm++; addr_q.push_back(int'(dp.bm_rd_addr)); end
      if (dp.eng_start) n_eng++;
      if (dp.outbuf_wr_req) begin n_wr++; idx_q.push_back(int'(dp.outbuf_wr_idx)); end
      if (dp.inbuf_release) n_rel++;
      if (sts_done) begin n_done++; done_cyc = cyc; end
      if (sts_aborted) n_ab++;
      if (dp.eng_flush) n_fl++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nb, ns;
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_stripe_num = '0;
    inbuf_val = 1'b0; ob_full = 1'b0; bm_stray = 1'b0; eng_stray = 1'b0;
    clear_mon();
    repeat (3) sync();

    // Reset state
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_aborted", sts_aborted, 0);
    check("rst_stripes", sts_stripes_done, 0);
    check("rst_pulses", {dp.inbuf_release, dp.bm_rd_req, dp.eng_start,
                         dp.eng_flush, dp.outbuf_wr_req}, 0);
    check("rst_addr", dp.bm_rd_addr, 0);
    check("rst_idx", dp.outbuf_wr_idx, 0);
    rst = 1'b0;
    sync();

    // 1: single stripe, 1-cycle responders
    clear_mon();
    inbuf_val = 1'b1;
    do_start(1);
    check("t1_busy", sts_busy, 1);
    wait_done("t1_done", 300);
    check_seq(1);
    check("t1_stripes", sts_stripes_done, 1);
    check("t1_latency", done_cyc - start_cyc, M * (4 * W + 1) + 2);
    check("t1_busy_end", sts_busy, 0);
    sync();

    // 2: three stripes, input withheld 20 cycles before stripe 2
    clear_mon();
    bm_lat = $urandom_range(1, 3);
    eng_lat = $urandom_range(1, 3);
    do_start(3);
    k = 0;
    while (n_rel < 1 && k < 1000) begin sync(); k++; end
    check("t2_first_release", n_rel, 1);
    inbuf_val = 1'b0;
    nb = n_bm;
    repeat (20) sync();
    check("t2_no_bm_while_wait", n_bm, nb);
    check("t2_busy_wait", sts_busy, 1);
    check("t2_stripes_wait", sts_stripes_done, 1);
    inbuf_val = 1'b1;
    wait_done("t2_done", 2000);
    check_seq(3);
    check("t2_stripes", sts_stripes_done, 3);
    check("t2_done_count", n_done, 1);
    bm_lat = 1; eng_lat = 1;
    sync();

    // 3: output buffer full when the first parity is ready
    clear_mon();
    ob_full = 1'b1;
    do_start(1);
    k = 0;
    while (n_eng < W && k < 200) begin sync(); k++; end
    check("t3_reach_parity", n_eng, W);
    repeat (10) sync();
    check("t3_no_wr_while_full", n_wr, 0);
    check("t3_no_bm_while_full", n_bm, W);
    ob_full = 1'b0;
    check("t3_wr_not_early", dp.outbuf_wr_req, 0);
    sync();
    check("t3_wr_after_full", dp.outbuf_wr_req, 1);
    check("t3_wr_idx", dp.outbuf_wr_idx, 0);
    wait_done("t3_done", 300);
    check_seq(1);
    sync();

    // 4: abort in ENG_WAIT of stripe 2, row 5
    clear_mon();
    do_start(2);
    k = 0;
    while (n_eng < M * W + 6 && k < 500) begin sync(); k++; end
    check("t4_reach_row", n_eng, M * W + 6);
    sync();
    cfg_abort = 1'b1;
    sync();
    cfg_abort = 1'b0;
    check("t4_flush", dp.eng_flush, 1);
    check("t4_aborted", sts_aborted, 1);
    check("t4_busy", sts_busy, 0);
    check("t4_stripes", sts_stripes_done, 1);
    repeat (10) sync();
    check("t4_no_release", n_rel, 1);
    check("t4_no_done", n_done, 0);
    check("t4_no_bm", n_bm, M * W + 6);
    check("t4_abort_count", n_ab, 1);
    do_start(1);
    wait_done("t4_restart_done", 300);
    check("t4_restart_release", n_rel, 2);
    check("t4_restart_stripes", sts_stripes_done, 1);
    sync();

    // 5: zero-stripe job
    clear_mon();
    do_start(0);
    check("t5_done", sts_done, 1);
    check("t5_busy", sts_busy, 0);
    repeat (5) sync();
    check("t5_no_traffic", n_bm + n_eng + n_wr + n_rel, 0);
    check("t5_done_count", n_done, 1);

    // 6: stray responses in WAIT_IN, second start mid-job ignored
    clear_mon();
    inbuf_val = 1'b0;
    do_start(2);
    repeat (3) sync();
    eng_stray = 1'b1; bm_stray = 1'b1;
    sync();
    eng_stray = 1'b0; bm_stray = 1'b0;
    repeat (3) sync();
    check("t6_no_bm_wait", n_bm, 0);
    check("t6_busy", sts_busy, 1);
    inbuf_val = 1'b1;
    k = 0;
    while (n_eng < 4 && k < 100) begin sync(); k++; end
    do_start(5);
    wait_done("t6_done", 600);
    check_seq(2);
    check("t6_stripes", sts_stripes_done, 2);
    repeat (3) sync();
    check("t6_idle", sts_busy, 0);

    // Randomized jobs with random latency and output back-pressure
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      ns = $urandom_range(1, 3);
      bm_lat = $urandom_range(1, 3);
      eng_lat = $urandom_range(1, 3);
      do_start(ns);
      k = 0;
      while (n_done == 0 && k < 3000) begin
        ob_full = ($urandom_range(0, 3) == 0);
        sync();
        k++;
      end
      ob_full = 1'b0;
      check("rand_done", n_done, 1);
      check_seq(ns);
      check("rand_stripes", sts_stripes_done, ns);
      sync();
    end
    bm_lat = 1; eng_lat = 1;

    // Reset mid-job
    clear_mon();
    do_start(2);
    repeat ($urandom_range(5, 60)) sync();
    rst = 1'b1;
    sync();
    check("t7_busy", sts_busy, 0);
    check("t7_stripes", sts_stripes_done, 0);
    check("t7_pulses", {dp.inbuf_release, dp.bm_rd_req, dp.eng_start, dp.eng_flush,
                        dp.outbuf_wr_req, sts_done, sts_aborted}, 0);
    rst = 1'b0;
    nb = n_bm + n_eng + n_wr + n_rel + n_done + n_ab + n_fl;
    repeat (6) sync();
    check("t7_quiet", n_bm + n_eng + n_wr + n_rel + n_done + n_ab + n_fl, nb);
    check("t7_idle", sts_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
